// File: rtl/cbus_pkg.sv
// Shared constants and types for the serial control bus.
package cbus_pkg;

   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned FRAME_LEN = 40;
   localparam int unsigned READ_BIT  = 7;
   localparam int unsigned IDX_W     = ADDR_W - 1;

   typedef logic [IDX_W-1:0] reg_idx_t;
   typedef logic [5:0]       bit_cnt_t;

endpackage

// File: rtl/cbus_regfile.sv
// Config register storage: one write port, one combinational read port.
// Indices at or above NUM_REGS are ignored on write and read back as zero.
module cbus_regfile
   import cbus_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  reg_idx_t          wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  reg_idx_t          rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [SEL_W-1:0]  wr_sel;
   logic [SEL_W-1:0]  rd_sel;
   logic              wr_hit;
   logic              rd_hit;

   assign wr_sel = wr_idx[SEL_W-1:0];
   assign rd_sel = rd_idx[SEL_W-1:0];
   assign wr_hit = wr_en && (32'(wr_idx) < NUM_REGS);
   assign rd_hit = 32'(rd_idx) < NUM_REGS;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_hit) begin
         regs[wr_sel] <= wr_data;
      end
   end

   assign rd_data = rd_hit ? regs[rd_sel] : '0;

endmodule

// File: rtl/control_bus.sv
// Serial control bus: 40-bit frames (8 addr + 32 data, MSB first) qualified by enable.
// Serial readback of reads is built only when CBUS_READBACK_EN is defined.
module control_bus
   import cbus_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32
) (
   input  logic              serial_clock,
   input  logic              reset,
   input  logic              serial_data_in,
   input  logic              enable,
   output logic              serial_data_out,
   output logic              config_strobe,
   output logic [IDX_W-1:0]  config_addr,
   output logic [DATA_W-1:0] config_data
);

   bit_cnt_t                bit_cnt;
   logic [FRAME_LEN-2:0]    shift_reg;
   logic [FRAME_LEN-1:0]    frame;
   logic [ADDR_W-1:0]       frame_addr;
   logic                    last_bit;
   logic                    wr_en;
   reg_idx_t                rd_idx;
   logic [DATA_W-1:0]       rd_data;

   // frame includes the bit arriving on this edge, so the 40th edge sees the whole word
   assign frame      = {shift_reg, serial_data_in};
   assign frame_addr = frame[FRAME_LEN-1 -: ADDR_W];
   assign last_bit   = enable && (bit_cnt == 6'(FRAME_LEN - 1));
   assign wr_en      = last_bit && !frame_addr[READ_BIT];

   always_ff @(posedge serial_clock or posedge reset) begin
      if (reset) begin
         bit_cnt       <= '0;
         shift_reg     <= '0;
         config_strobe <= 1'b0;
         config_addr   <= '0;
         config_data   <= '0;
      end else begin
         config_strobe <= 1'b0;
         if (!enable) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
         end else begin
            shift_reg <= frame[FRAME_LEN-2:0];
            bit_cnt   <= last_bit ? '0 : bit_cnt + 6'd1;
            if (wr_en) begin
               config_strobe <= 1'b1;
               config_addr   <= frame_addr[IDX_W-1:0];
               config_data   <= frame[DATA_W-1:0];
            end
         end
      end
   end

   cbus_regfile #(
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .clk     (serial_clock),
      .rst     (reset),
      .wr_en   (wr_en),
      .wr_idx  (frame_addr[IDX_W-1:0]),
      .wr_data (frame[DATA_W-1:0]),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

`ifdef CBUS_READBACK_EN
   logic       addr_edge;
   logic       in_window;
   logic       rd_flag_q;
   reg_idx_t   rd_idx_q;
   logic       sdo_q;
   logic [4:0] bit_sel;

   // on the 8th edge the address is still in flight, so read straight from the frame
   assign addr_edge = enable && (bit_cnt == 6'(ADDR_W - 1));
   assign in_window = enable && (bit_cnt >= 6'(ADDR_W)) && (bit_cnt <= 6'(FRAME_LEN - 2));
   assign bit_sel   = 5'(6'(FRAME_LEN - 2) - bit_cnt);
   assign rd_idx    = addr_edge ? frame[IDX_W-1:0] : rd_idx_q;

   always_ff @(posedge serial_clock or posedge reset) begin
      if (reset) begin
         rd_flag_q <= 1'b0;
         rd_idx_q  <= '0;
         sdo_q     <= 1'b0;
      end else begin
         sdo_q <= 1'b0;
         if (addr_edge) begin
            rd_flag_q <= frame[READ_BIT];
            rd_idx_q  <= frame[IDX_W-1:0];
            sdo_q     <= frame[READ_BIT] & rd_data[DATA_W-1];
         end else if (in_window && rd_flag_q) begin
            sdo_q <= rd_data[bit_sel];
         end
      end
   end

   assign serial_data_out = sdo_q & enable;
`else
   logic unused_rd_data;

   assign rd_idx          = '0;
   assign unused_rd_data  = ^rd_data;
   assign serial_data_out = 1'b0;
`endif

endmodule

// File: tb/tb_control_bus.sv
// Directed self-checking bench for control_bus; readback expectations follow CBUS_READBACK_EN.
module tb_control_bus;

   localparam int unsigned NREGS = 32;

   logic        serial_clock = 1'b0;
   logic        reset = 1'b1;
   logic        serial_data_in = 1'b0;
   logic        enable = 1'b0;
   logic        serial_data_out;
   logic        config_strobe;
   logic [6:0]  config_addr;
   logic [31:0] config_data;

   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   int unsigned strobe_cnt = 0;
   logic [31:0] model [NREGS];

   always #5 serial_clock = ~serial_clock;

   always @(posedge serial_clock) begin
      #1;
      if (config_strobe === 1'b1) strobe_cnt++;
   end

   control_bus #(
      .NUM_REGS (NREGS)
   ) dut (
      .serial_clock    (serial_clock),
      .reset           (reset),
      .serial_data_in  (serial_data_in),
      .enable          (enable),
      .serial_data_out (serial_data_out),
      .config_strobe   (config_strobe),
      .config_addr     (config_addr),
      .config_data     (config_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   function automatic logic [31:0] rb(input logic [31:0] v);
`ifdef CBUS_READBACK_EN
      return v;
`else
      return 32'h0;
`endif
   endfunction

   // called at a negedge; returns at a negedge
   task automatic send_bits(input logic [39:0] f, input int unsigned n, output logic [31:0] rd);
      rd = '0;
      for (int unsigned i = 0; i < n; i++) begin
         enable = 1'b1;
         serial_data_in = f[39-i];
         @(posedge serial_clock);
         #1;
         if (i >= 7 && i <= 38) rd[38-i] = serial_data_out;
         @(negedge serial_clock);
      end
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) begin
         enable = 1'b0;
         serial_data_in = 1'b0;
         @(negedge serial_clock);
      end
   endtask

   task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
      logic [31:0] rd;
      send_bits({a, d}, 40, rd);
      check("wr_strobe_hi", {31'b0, config_strobe}, 32'h1);
      check("wr_addr", {25'b0, config_addr}, {25'b0, a[6:0]});
      check("wr_data", config_data, d);
      check("wr_sdo_zero", rd, 32'h0);
      if (int'(a[6:0]) < int'(NREGS)) model[a[4:0]] = d;
      idle(1);
      check("wr_strobe_lo", {31'b0, config_strobe}, 32'h0);
   endtask

   task automatic read_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      send_bits({a, 32'h5A5AC3C3}, 40, rd);
      check(tag, rd, rb(exp));
      check("rd_no_strobe", {31'b0, config_strobe}, 32'h0);
      idle(1);
   endtask

   task automatic check_regs(input string tag);
      int unsigned nbad;
      nbad = 0;
      for (int i = 0; i < int'(NREGS); i++)
         if (dut.u_regfile.regs[i] !== model[i]) nbad++;
      check(tag, nbad, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned c0;
      logic [31:0] scratch;
      for (int i = 0; i < int'(NREGS); i++) model[i] = '0;

      reset = 1'b1;
      repeat (3) @(negedge serial_clock);
      check("rst_strobe", {31'b0, config_strobe}, 32'h0);
      check("rst_addr", {25'b0, config_addr}, 32'h0);
      check("rst_data", config_data, 32'h0);
      check("rst_sdo", {31'b0, serial_data_out}, 32'h0);
      check_regs("rst_regs");
      reset = 1'b0;
      idle(2);

      // write then read; read frame data bits must not disturb registers
      write_reg(8'h01, 32'hDEADBEEF);
      check_regs("regs_after_wr01");
      read_reg("rd_81", 8'h81, 32'hDEADBEEF);
      check_regs("regs_after_rd81");
      check("data_kept_after_rd", config_data, 32'hDEADBEEF);

      write_reg(8'h03, 32'hDDEEFF01);
      write_reg(8'h13, 32'hFFFFFFFF);
      write_reg(8'h17, 32'h1234FEDC);
      read_reg("rd_83", 8'h83, 32'hDDEEFF01);
      read_reg("rd_93", 8'h93, 32'hFFFFFFFF);
      read_reg("rd_97", 8'h97, 32'h1234FEDC);
      read_reg("rd_82", 8'h82, 32'h0);
      check_regs("regs_multi");

      // abort after 20 bits
      c0 = strobe_cnt;
      send_bits({8'h05, 32'hCAFEF00D}, 20, scratch);
      idle(2);
      check("abort_no_strobe", strobe_cnt - c0, 32'h0);
      read_reg("rd_85_abort", 8'h85, 32'h0);
      check_regs("regs_after_abort");

      // out-of-range index
      c0 = strobe_cnt;
      write_reg(8'h40, 32'hAAAA5555);
      check("oor_one_strobe", strobe_cnt - c0, 32'h1);
      check_regs("regs_after_oor");
      read_reg("rd_c0", 8'hC0, 32'h0);

      // asynchronous reset pulse between edges
      reset = 1'b1;
      #2;
      check("async_rst_addr", {25'b0, config_addr}, 32'h0);
      check("async_rst_data", config_data, 32'h0);
      reset = 1'b0;
      @(negedge serial_clock);
      for (int i = 0; i < int'(NREGS); i++) model[i] = '0;
      check_regs("regs_after_rst");
      read_reg("rd_81_after_rst", 8'h81, 32'h0);

      // reset in the middle of a frame; next frame must start at bit 1 right after release
      write_reg(8'h06, 32'h600DF00D);
      send_bits({8'h02, 32'h11111111}, 25, scratch);
      reset = 1'b1;
      #1;
      for (int i = 0; i < int'(NREGS); i++) model[i] = '0;
      check_regs("regs_midframe_rst");
      @(negedge serial_clock);
      reset = 1'b0;
      write_reg(8'h04, 32'h0F0F0F0F);
      read_reg("rd_84_after_rst", 8'h84, 32'h0F0F0F0F);
      check_regs("regs_final");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
